// File: rtl/string_pov_receiver_if.sv
// Signal bundle between the POV string receiver and its line/display side.
// The receiver takes the slave view; the driver of the serial line and the
// consumer of the string image take the master view.
interface string_pov_receiver_if #(
  parameter int N_CHARS = 11,
  parameter int CHAR_W  = 7
);
  logic                          RecvBit;
  logic [0:N_CHARS*CHAR_W-1]     StringPOV;
  logic                          Complete;
  logic                          ParityError;
  logic                          FrameError;
  logic                          Busy;

  modport master (
    output RecvBit,
    input  StringPOV, Complete, ParityError, FrameError, Busy
  );

  modport slave (
    input  RecvBit,
    output StringPOV, Complete, ParityError, FrameError, Busy
  );
endinterface

// File: rtl/string_pov_receiver.sv
// POV string link receiver: recovers 10-bit character frames (start, 7 data
// LSB first, even parity, stop) and assembles up to N_CHARS characters into a
// string image. A null character or a full string ends the string; the image
// is then published on StringPOV together with a one-cycle Complete pulse.
module string_pov_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int N_CHARS      = 11,
  parameter int CHAR_W       = 7
) (
  input  logic                 clk,
  input  logic                 Reset,
  string_pov_receiver_if.slave bus
);

  localparam int POV_W  = N_CHARS * CHAR_W;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BASE_W = $clog2(POV_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(CHAR_W - 1);
  localparam logic [3:0]       LAST_CHAR = 4'(N_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RESYNC, S_STORE, S_DONE
  } state_t;

  state_t              state, next_state;
  logic                sync1, sync2, line_q;
  logic                line, fall;
  logic [CNT_W-1:0]    baud_cnt;
  logic                half_tick, bit_tick;
  logic [2:0]          bit_idx;
  logic [CHAR_W-1:0]   char_buf;
  logic                sticky_perr;
  logic [3:0]          char_idx;
  logic [BASE_W-1:0]   slot_base;
  logic [0:POV_W-1]    shadow;
  logic [0:POV_W-1]    string_pov;
  logic                parity_error, complete, frame_error, busy;

  assign line      = sync2;
  assign fall      = line_q & ~sync2;
  assign half_tick = (baud_cnt == HALF_LAST);
  assign bit_tick  = (baud_cnt == BIT_LAST);
  assign slot_base = BASE_W'(char_idx * CHAR_W);

  // Two-flop synchroniser for the asynchronous line plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!Reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= bus.RecvBit;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: next_state gets a default before the case so no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:   if (fall) next_state = S_START;
      S_START:  if (half_tick) next_state = line ? S_IDLE : S_DATA;
      S_DATA:   if (bit_tick && bit_idx == LAST_BIT) next_state = S_PARITY;
      S_PARITY: if (bit_tick) next_state = S_STOP;
      S_STOP:   if (bit_tick) next_state = line ? S_STORE : S_RESYNC;
      S_RESYNC: if (line) next_state = S_IDLE;
      S_STORE:  next_state = (char_buf == '0 || char_idx == LAST_CHAR) ? S_DONE : S_IDLE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Baud counter: half a bit to the start-bit centre, then whole bits between mid-bit samples.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      baud_cnt <= '0;
    end else begin
      case (state)
        S_START:                  baud_cnt <= half_tick ? '0 : baud_cnt + CNT_W'(1);
        S_DATA, S_PARITY, S_STOP: baud_cnt <= bit_tick  ? '0 : baud_cnt + CNT_W'(1);
        default:                  baud_cnt <= '0;
      endcase
    end
  end

  // Character assembly, parity accumulation, shadow string and published image.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      bit_idx      <= '0;
      char_buf     <= '0;
      sticky_perr  <= 1'b0;
      char_idx     <= '0;
      // NOTE: the shadow string is plain flops and is reset so unfilled slots always read 0.
      shadow       <= '0;
      string_pov   <= '0;
      parity_error <= 1'b0;
    end else begin
      case (state)
        S_DATA: if (bit_tick) begin
          char_buf[bit_idx] <= line;
          bit_idx           <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 3'd1;
        end
        S_PARITY: if (bit_tick) sticky_perr <= sticky_perr | (line ^ (^char_buf));
        S_STORE: begin
          shadow[slot_base +: CHAR_W] <= char_buf;
          if (next_state == S_IDLE) char_idx <= char_idx + 4'd1;
        end
        S_DONE: begin
          string_pov   <= shadow;
          parity_error <= sticky_perr;
          shadow       <= '0;
          char_idx     <= '0;
          sticky_perr  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs, decoded one cycle ahead so they align with the state they describe.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      complete    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      complete    <= (next_state == S_DONE);
      frame_error <= (state == S_STOP) && bit_tick && !line;
      busy        <= (next_state != S_IDLE);
    end
  end

  assign bus.StringPOV   = string_pov;
  assign bus.Complete    = complete;
  assign bus.ParityError = parity_error;
  assign bus.FrameError  = frame_error;
  assign bus.Busy        = busy;

endmodule

// File: tb/tb_string_pov_receiver.sv
// Self-checking bench for string_pov_receiver: directed vector table, hand
// sequences for glitch / frame error / mid-frame reset, and a randomized run
// against a string-level reference model.
module tb_string_pov_receiver;

  localparam int CPB = 16;
  // Line edge to Complete: 2 sync flops + edge flop, half a bit to the start
  // centre, nine whole bits to the stop centre, one STORE cycle before DONE.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  string_pov_receiver_if bus ();
  string_pov_receiver #(.CLKS_PER_BIT(CPB), .N_CHARS(11), .CHAR_W(7)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Completion monitor: StringPOV/ParityError are taken the cycle after Complete.
  typedef struct {
    logic [0:76] pov;
    logic        perr;
    int unsigned cyc;
    logic        busy_at;
    logic        busy_after;
  } comp_t;

  comp_t act_q[$];
  comp_t exp_q[$];
  comp_t pend_rec;
  logic  pend = 1'b0;
  int    fe_cnt = 0;

  always @(negedge clk) begin
    if (pend) begin
      pend_rec.pov        = bus.StringPOV;
      pend_rec.perr       = bus.ParityError;
      pend_rec.busy_after = bus.Busy;
      act_q.push_back(pend_rec);
      pend = 1'b0;
    end
    if (bus.Complete === 1'b1) begin
      pend_rec.cyc     = cyc;
      pend_rec.busy_at = bus.Busy;
      pend = 1'b1;
    end
    if (bus.FrameError === 1'b1) fe_cnt++;
  end

  int unsigned last_start;

  // Drives one frame; called and returns at a falling clock edge. A bad stop
  // bit leaves the line low on return.
  task automatic send_frame(input logic [6:0] ch, input logic flip, input logic stop_bad);
    logic [9:0] bits;
    bits = {~stop_bad, (^ch) ^ flip, ch, 1'b0};
    last_start = cyc;
    for (int b = 0; b < 10; b++) begin
      bus.RecvBit = bits[b];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Reference model at string level.
  logic [6:0] m_chars [11];
  int         m_len = 0;
  logic       m_perr = 1'b0;

  function automatic logic [0:76] pack(input logic [6:0] c [11], input int len);
    logic [0:76] p;
    p = '0;
    for (int k = 0; k < 11; k++) p = {p[7:76], (k < len) ? c[k] : 7'h00};
    return p;
  endfunction

  task automatic model_frame(input logic [6:0] ch, input logic flip, input logic bad,
                             input int unsigned start);
    comp_t e;
    m_perr = m_perr | flip;
    if (!bad) begin
      m_chars[m_len] = ch;
      m_len++;
      if (ch == 7'h00 || m_len == 11) begin
        e.pov = pack(m_chars, m_len);
        e.perr = m_perr;
        e.cyc = start + LAT;
        e.busy_at = 1'b1;
        e.busy_after = 1'b0;
        exp_q.push_back(e);
        m_len = 0;
        m_perr = 1'b0;
        for (int k = 0; k < 11; k++) m_chars[k] = 7'h00;
      end
    end
  endtask

  typedef struct {
    logic [6:0]  ch [11];
    int          n;
    logic [10:0] flip;
    logic [0:76] exp_pov;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    logic [9:0] bits;
    int nbad;

    vecs[0].ch = '{0: 7'h41, default: 7'h00};
    vecs[0].n = 2;  vecs[0].flip = '0;
    vecs[0].exp_pov = {7'h41, 70'd0};  vecs[0].exp_perr = 1'b0;
    vecs[1].ch = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09, 7'h0A, 7'h0B};
    vecs[1].n = 11; vecs[1].flip = '0;
    vecs[1].exp_pov = {7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09, 7'h0A, 7'h0B};
    vecs[1].exp_perr = 1'b0;
    vecs[2].ch = '{0: 7'h03, default: 7'h00};
    vecs[2].n = 2;  vecs[2].flip = 11'b1;
    vecs[2].exp_pov = {7'h03, 70'd0};  vecs[2].exp_perr = 1'b1;
    vecs[3].ch = '{0: 7'h55, 1: 7'h2A, default: 7'h00};
    vecs[3].n = 3;  vecs[3].flip = '0;
    vecs[3].exp_pov = {7'h55, 7'h2A, 63'd0};  vecs[3].exp_perr = 1'b0;
    vecs[4].ch = '{default: 7'h00};
    vecs[4].n = 1;  vecs[4].flip = '0;
    vecs[4].exp_pov = 77'd0;  vecs[4].exp_perr = 1'b0;

    // Reset state
    bus.RecvBit = 1'b1;
    repeat (3) @(negedge clk);
    check("reset StringPOV", bus.StringPOV, 77'd0);
    check("reset Complete", bus.Complete, 1'b0);
    check("reset ParityError", bus.ParityError, 1'b0);
    check("reset FrameError", bus.FrameError, 1'b0);
    check("reset Busy", bus.Busy, 1'b0);
    Reset = 1'b1;
    repeat (5) @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      act_q.delete();
      fe0 = fe_cnt;
      for (int i = 0; i < vecs[v].n; i++) send_frame(vecs[v].ch[i], vecs[v].flip[i], 1'b0);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d completions", v), act_q.size(), 1);
      if (act_q.size() > 0) begin
        check($sformatf("vec%0d StringPOV", v), act_q[0].pov, vecs[v].exp_pov);
        check($sformatf("vec%0d ParityError", v), act_q[0].perr, vecs[v].exp_perr);
        check($sformatf("vec%0d latency", v), act_q[0].cyc, last_start + LAT);
        check($sformatf("vec%0d Busy at Complete", v), act_q[0].busy_at, 1'b1);
        check($sformatf("vec%0d Busy after Complete", v), act_q[0].busy_after, 1'b0);
      end
      check($sformatf("vec%0d FrameError count", v), fe_cnt - fe0, 0);
    end

    // Bad stop bit on first char, line held low, then a clean 'B' string
    act_q.delete();
    fe0 = fe_cnt;
    send_frame(7'h12, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    check("resync Busy held", bus.Busy, 1'b1);
    check("resync FrameError pulses", fe_cnt - fe0, 1);
    check("resync no Complete", act_q.size(), 0);
    bus.RecvBit = 1'b1;
    repeat (10) @(negedge clk);
    check("resync Busy released", bus.Busy, 1'b0);
    send_frame(7'h42, 1'b0, 1'b0);
    send_frame(7'h00, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("after resync completions", act_q.size(), 1);
    if (act_q.size() > 0) begin
      check("after resync StringPOV", act_q[0].pov, {7'h42, 70'd0});
      check("after resync ParityError", act_q[0].perr, 1'b0);
    end

    // 3-cycle glitch on an idle line
    act_q.delete();
    fe0 = fe_cnt;
    bus.RecvBit = 1'b0;
    repeat (3) @(negedge clk);
    bus.RecvBit = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch Busy raised", bus.Busy, 1'b1);
    repeat (30) @(negedge clk);
    check("glitch Busy dropped", bus.Busy, 1'b0);
    check("glitch no Complete", act_q.size(), 0);
    check("glitch no FrameError", fe_cnt - fe0, 0);
    check("glitch StringPOV held", bus.StringPOV, {7'h42, 70'd0});

    // Reset during the data bits of the 5th char
    send_frame(7'h03, 1'b1, 1'b0);
    send_frame(7'h00, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("pre-reset ParityError", bus.ParityError, 1'b1);
    for (int i = 0; i < 4; i++) send_frame(7'(8'h11 + i), 1'b0, 1'b0);
    bits = {1'b1, ^7'h15, 7'h15, 1'b0};
    for (int i = 0; i < 40; i++) begin
      bus.RecvBit = bits[i / 16];
      @(negedge clk);
    end
    Reset = 1'b0;
    #1;
    check("midreset StringPOV", bus.StringPOV, 77'd0);
    check("midreset Complete", bus.Complete, 1'b0);
    check("midreset ParityError", bus.ParityError, 1'b0);
    check("midreset FrameError", bus.FrameError, 1'b0);
    check("midreset Busy", bus.Busy, 1'b0);
    @(negedge clk);
    bus.RecvBit = 1'b1;
    repeat (5) @(negedge clk);
    Reset = 1'b1;
    repeat (5) @(negedge clk);
    act_q.delete();
    send_frame(7'h21, 1'b0, 1'b0);
    send_frame(7'h22, 1'b0, 1'b0);
    send_frame(7'h00, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("post-reset completions", act_q.size(), 1);
    if (act_q.size() > 0) begin
      check("post-reset StringPOV", act_q[0].pov, {7'h21, 7'h22, 63'd0});
      check("post-reset latency", act_q[0].cyc, last_start + LAT);
    end

    // Randomized strings against the reference model
    act_q.delete();
    exp_q.delete();
    fe0 = fe_cnt;
    nbad = 0;
    for (int k = 0; k < 11; k++) m_chars[k] = 7'h00;
    for (int s = 0; s < 10; s++) begin
      int nchar;
      nchar = $urandom_range(0, 11);
      for (int i = 0; i <= nchar && i < 11; i++) begin
        logic [6:0] ch;
        logic flip, bad;
        ch   = (i < nchar) ? 7'($urandom_range(1, 127)) : 7'h00;
        flip = ($urandom_range(0, 7) == 0);
        bad  = ($urandom_range(0, 11) == 0);
        send_frame(ch, flip, bad);
        model_frame(ch, flip, bad, last_start);
        if (bad) begin
          nbad++;
          repeat ($urandom_range(0, 30)) @(negedge clk);
          bus.RecvBit = 1'b1;
          repeat (6) @(negedge clk);
        end
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);
    check("random completions", act_q.size(), exp_q.size());
    check("random FrameError count", fe_cnt - fe0, nbad);
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check($sformatf("random%0d StringPOV", i), act_q[i].pov, exp_q[i].pov);
      check($sformatf("random%0d ParityError", i), act_q[i].perr, exp_q[i].perr);
      check($sformatf("random%0d latency", i), act_q[i].cyc, exp_q[i].cyc);
      check($sformatf("random%0d Busy after", i), act_q[i].busy_after, exp_q[i].busy_after);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
